// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Collects one-cycle result pulses from five functional units (ALU, MEM, MUL,
// DIV, JUMP), buffers each FU's results in its own small FIFO, and broadcasts
// at most one result per cycle on the common data bus (CDB).
//
// Configuration macro:
//   CDB_RR_EN  defined   -> round-robin grant, starting after the last winner
//              undefined -> fixed priority, lowest FU index wins
//
// Parameter:
//   DEPTH       result-buffer entries per FU (1..4)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   fu_finish   per-FU result pulse (bit i = FU i)
//   fu_rs_num   per-FU destination RS tag, 8 bits per FU; tag 0 is ignored
//   fu_data     per-FU result value, 32 bits per FU
//   fu_pc       per-FU instruction PC, 32 bits per FU (debug)
//   fu_stall    per-FU back-pressure, high while that FU's FIFO is full
//   cdb_valid   broadcast valid
//   cdb_rs_num  broadcast RS tag (0 when idle)
//   cdb_data    broadcast value (0 when idle)
//   cdb_pc      broadcast PC (0 when idle)
//   ovf_err     sticky flag: a result arrived at a full FIFO and was dropped
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   fu_finish,
    input  logic [39:0]  fu_rs_num,
    input  logic [159:0] fu_data,
    input  logic [159:0] fu_pc,
    output logic [4:0]   fu_stall,
    output logic         cdb_valid,
    output logic [7:0]   cdb_rs_num,
    output logic [31:0]  cdb_data,
    output logic [31:0]  cdb_pc,
    output logic         ovf_err
);

    localparam int NFU  = 5;
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTRW-1:0] ptr_t;
    typedef logic [2:0]      cnt_t;
    typedef logic [2:0]      fuIdx_t;

    logic [7:0]     rsMem_q   [NFU][DEPTH];
    logic [31:0]    dataMem_q [NFU][DEPTH];
    logic [31:0]    pcMem_q   [NFU][DEPTH];
    ptr_t           wrPtr_q   [NFU];
    ptr_t           rdPtr_q   [NFU];
    cnt_t           count_q   [NFU];
    cnt_t           count_d   [NFU];

    logic [NFU-1:0] notEmpty;
    logic [NFU-1:0] push;
    logic [NFU-1:0] accept;
    logic [NFU-1:0] grant;
    logic           anyGrant;
    fuIdx_t         grantIdx;

    logic           cdbValid_q, cdbValid_d;
    logic [7:0]     cdbRs_q,    cdbRs_d;
    logic [31:0]    cdbData_q,  cdbData_d;
    logic [31:0]    cdbPc_q,    cdbPc_d;
    logic           ovf_q,      ovf_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic ptr_t nextPtr(input ptr_t p);
        if (int'(p) == DEPTH - 1) return '0;
        return p + 1'b1;
    endfunction

    // FIFO status straight from the registered counts, so stall never
    // depends combinationally on this cycle's finish pulses.
    always_comb begin
        notEmpty = '0;
        fu_stall = '0;
        push     = '0;
        for (int i = 0; i < NFU; i++) begin
            notEmpty[i] = (count_q[i] != '0);
            fu_stall[i] = (count_q[i] == cnt_t'(DEPTH));
            push[i]     = fu_finish[i] && (fu_rs_num[8*i +: 8] != 8'h00);
        end
    end

`ifdef CDB_RR_EN
    logic [2:0] rrPtr_q, rrPtr_d;

    // Round-robin: scan the five FUs starting at the pointer, first
    // non-empty one wins.
    always_comb begin
        anyGrant = 1'b0;
        grantIdx = '0;
        for (int k = 0; k < NFU; k++) begin
            if (!anyGrant && notEmpty[(int'(rrPtr_q) + k) % NFU]) begin
                anyGrant = 1'b1;
                grantIdx = fuIdx_t'((int'(rrPtr_q) + k) % NFU);
            end
        end
    end

    // Next search starts just after the FU that won, wrapping JUMP -> ALU.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (anyGrant) rrPtr_d = (grantIdx == 3'd4) ? 3'd0 : grantIdx + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rrPtr_q <= '0;
        else     rrPtr_q <= rrPtr_d;
    end
`else
    // Fixed priority: scanning downward leaves the lowest index as winner.
    always_comb begin
        anyGrant = 1'b0;
        grantIdx = '0;
        for (int i = NFU - 1; i >= 0; i--) begin
            if (notEmpty[i]) begin
                anyGrant = 1'b1;
                grantIdx = fuIdx_t'(i);
            end
        end
    end
`endif

    // A full FIFO can still take a write when its head leaves on the same
    // edge; any other write to a full FIFO is dropped and flagged.
    always_comb begin
        grant = '0;
        if (anyGrant) grant[grantIdx] = 1'b1;
        accept = '0;
        for (int i = 0; i < NFU; i++) begin
            accept[i]  = push[i] && (!fu_stall[i] || grant[i]);
            count_d[i] = count_q[i] + cnt_t'(accept[i]) - cnt_t'(grant[i]);
        end
        ovf_d = ovf_q | (|(push & ~accept));
    end

    // The granted head is copied into the broadcast registers; an idle
    // cycle loads zeros.
    always_comb begin
        cdbValid_d = anyGrant;
        cdbRs_d    = '0;
        cdbData_d  = '0;
        cdbPc_d    = '0;
        if (anyGrant) begin
            cdbRs_d   = rsMem_q[grantIdx][rdPtr_q[grantIdx]];
            cdbData_d = dataMem_q[grantIdx][rdPtr_q[grantIdx]];
            cdbPc_d   = pcMem_q[grantIdx][rdPtr_q[grantIdx]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NFU; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    rsMem_q[i][j]   <= '0;
                    dataMem_q[i][j] <= '0;
                    pcMem_q[i][j]   <= '0;
                end
                wrPtr_q[i] <= '0;
                rdPtr_q[i] <= '0;
                count_q[i] <= '0;
            end
            cdbValid_q <= 1'b0;
            cdbRs_q    <= '0;
            cdbData_q  <= '0;
            cdbPc_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NFU; i++) begin
                if (accept[i]) begin
                    rsMem_q[i][wrPtr_q[i]]   <= fu_rs_num[8*i +: 8];
                    dataMem_q[i][wrPtr_q[i]] <= fu_data[32*i +: 32];
                    pcMem_q[i][wrPtr_q[i]]   <= fu_pc[32*i +: 32];
                    wrPtr_q[i]               <= nextPtr(wrPtr_q[i]);
                end
                if (grant[i]) rdPtr_q[i] <= nextPtr(rdPtr_q[i]);
                count_q[i] <= count_d[i];
            end
            cdbValid_q <= cdbValid_d;
            cdbRs_q    <= cdbRs_d;
            cdbData_q  <= cdbData_d;
            cdbPc_q    <= cdbPc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cdb_valid  = cdbValid_q;
    assign cdb_rs_num = cdbRs_q;
    assign cdb_data   = cdbData_q;
    assign cdb_pc     = cdbPc_q;
    assign ovf_err    = ovf_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: result-buffer entries per FU, legal values 1..4.
REQ-002 clk  input  1  main (debug) clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 fu_finish  input  5  per-FU one-cycle result pulse; index 0=ALU, 1=MEM, 2=MUL, 3=DIV, 4=JUMP.
REQ-005 fu_rs_num  input  40  per-FU destination RS tag, 8 bits each; FU i at [8i+7:8i].
REQ-006 fu_data  input  160  per-FU result, 32 bits each; FU i at [32i+31:32i].
REQ-007 fu_pc  input  160  per-FU instruction PC, 32 bits each, debug only.
REQ-008 fu_stall  output  5  per-FU back-pressure; FU i holds its result while high.
REQ-009 cdb_valid  output  1  broadcast valid this cycle.
REQ-010 cdb_rs_num  output  8  broadcast RS tag; 0 when cdb_valid low.
REQ-011 cdb_data  output  32  broadcast value; 0 when cdb_valid low.
REQ-012 cdb_pc  output  32  broadcast PC; 0 when cdb_valid low.
REQ-013 ovf_err  output  1  sticky error: a result was dropped.

Function
REQ-014 One DEPTH-entry FIFO per FU holds {rs_num, data, pc}; entries leave each FIFO in arrival order.
REQ-015 Capture: fu_finish[i] high at a posedge with fu_rs_num[i]!=0 writes FIFO i; rs_num 0 is ignored and never stored.
REQ-016 Write into full FIFO i accepted only if FIFO i pops on the same edge; otherwise data dropped, ovf_err set.
REQ-017 fu_stall[i] = (count_i == DEPTH), derived from registered count; no combinational path from fu_finish.
REQ-018 Each cycle at most one non-empty FIFO granted; granted head popped and loaded into cdb_* registers on the same edge.
REQ-019 No FIFO non-empty: cdb_valid, cdb_rs_num, cdb_data, cdb_pc loaded with 0.
REQ-020 Latency: finish sampled at edge N, no contention -> cdb_valid high in the cycle after edge N+1; exactly one cycle wide per entry.
REQ-021 Ungranted heads stay; no entry lost or duplicated; each accepted entry broadcast exactly once.
REQ-022 Simultaneous finishes from k FUs with empty FIFOs broadcast in k consecutive cycles in grant order.
REQ-023 Counts 0..DEPTH; read/write pointers wrap modulo DEPTH.

Reset
REQ-024 rst high asynchronously clears all FIFOs, counts, pointers, RR pointer, cdb_* outputs, ovf_err to 0.
REQ-025 fu_stall 0 during and after reset; rst mid-burst discards all buffered entries with no further broadcast.
REQ-026 First capture possible at the first posedge with rst low.

Configuration
REQ-027 Macro CDB_RR_EN defined: round-robin grant; search starts at index after last granted FU (reset pointer 0), wraps 4->0.
REQ-028 CDB_RR_EN undefined: fixed priority, lowest index (ALU) wins; RR pointer logic absent.

Verification
REQ-029 Single: ALU finish, rs_num=8'h11, data=32'h5 at edge N -> cdb_valid=1, rs_num=8'h11, data=32'h5 in the cycle after N+1 only.
REQ-030 Collision: ALU(8'h11), MUL(8'h31), DIV(8'h41) same edge -> three consecutive broadcasts 11,31,41 (both configurations, RR from reset).
REQ-031 RR fairness (CDB_RR_EN): ALU and JUMP finishing every cycle -> grants alternate ALU, JUMP, ALU, JUMP; ALU never wins twice in a row.
REQ-032 Full, DEPTH=2: DIV finishes 3 times while MEM holds priority -> fu_stall[3]=1 after second capture; third dropped, ovf_err=1 and stays 1.
REQ-033 Tag 0: MEM finish with rs_num=0 -> no broadcast, count unchanged, ovf_err=0.
REQ-034 Reset mid-operation: 4 entries buffered, rst pulsed between edges -> all outputs 0 immediately; no broadcast after release until a new finish.
